// File: rtl/seg7_scan_pkg.sv
// rtl/seg7_scan_pkg.sv - shared constants and glyph table for the 8-digit seven-segment scanner
// Contents: data bus width, active-low segment/anode "all off" patterns, hex glyph lookup.
package seg7_scan_pkg;

    localparam int         DATA_W  = 32;
    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0-F.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational nibble to active-low seven-segment decoder
// Ports: nibble_i [3:0] hex digit in; seg_o [6:0] active-low {g..a} out.
module seg7_decode
    import seg7_scan_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_glyph(nibble_i);

endmodule

// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - multiplexed 8-digit hex display scanner with frame-synchronous shadow register
// Ports: clk, rst (sync, active-high); data_i [31:0] value to show; en_i display enable;
//        blank_lz_i leading-zero blanking; seg_o [7:0] {dp,g..a} active-low;
//        an_o [7:0] digit selects active-low (bit 0 = rightmost); frame_o shadow-load pulse.
module seg7_scan
    import seg7_scan_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              en_i,
    input  logic              blank_lz_i,
    output logic [7:0]        seg_o,
    output logic [7:0]        an_o,
    output logic              frame_o
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [7:0]        seg_q, seg_d;
    logic [7:0]        an_q, an_d;
    logic              frame_q, frame_d;

    logic              slot_end;
    logic [4:0]        nib_base;
    logic [3:0]        nibble;
    logic [6:0]        glyph;
    logic              lz_blank;

    assign slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    assign nib_base = {idx_q, 2'b00};
    assign nibble   = shadow_q[nib_base +: 4];

    // A digit is a leading zero when it and every more significant nibble are zero;
    // the rightmost digit always stays lit so a zero value still shows "0".
    assign lz_blank = blank_lz_i && (idx_q != 3'd0) && ((shadow_q >> nib_base) == '0);

    seg7_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (glyph)
    );

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        frame_d  = 1'b0;
        an_d     = AN_OFF;
        seg_d    = SEG_OFF;

        if (en_i) begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
                // Latch the new value only at the end of digit 7 so one frame never mixes two values.
                if (idx_q == 3'd7) begin
                    shadow_d = data_i;
                    frame_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (!lz_blank) begin
                seg_d = {1'b1, glyph};
                // Keep all anodes off at the start of a slot so the previous digit's
                // segments do not ghost onto the newly selected digit.
                if (cnt_q >= CNT_W'(BLANK_CYC)) begin
                    an_d = ~(8'h01 << idx_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            frame_q  <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - self-checking bench for seg7_scan against a position-based display model
module tb_seg7_scan;

    localparam int DIV   = 8;
    localparam int BLK   = 2;
    localparam int FRAME = DIV * 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_i = 1'b1;
    logic        blank_lz_i = 1'b0;
    logic [31:0] data_i = 32'h1234_5678;
    logic [7:0]  seg_o;
    logic [7:0]  an_o;
    logic        frame_o;

    int checks = 0;
    int failures = 0;

    // Model: number of enabled cycles since reset, and the value currently latched for display.
    int unsigned pos = 0;
    logic [31:0] shadow = '0;

    logic [6:0] glyph_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seg7_scan #(.REFRESH_DIV(DIV), .BLANK_CYC(BLK)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_i     (data_i),
        .en_i       (en_i),
        .blank_lz_i (blank_lz_i),
        .seg_o      (seg_o),
        .an_o       (an_o),
        .frame_o    (frame_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s pos=%0d got=%h want=%h", tag, pos, obs, exp);
        end
    endtask

    // Advance one clock and compare outputs with what the display should show for the
    // model state before that edge and the inputs applied at that edge.
    task automatic step();
        int          c;
        int          d;
        logic [31:0] upper;
        logic        lz;
        logic [7:0]  e_an;
        logic [7:0]  e_seg;
        logic        e_fr;
        c     = int'(pos % DIV);
        d     = int'((pos / DIV) % 8);
        upper = shadow >> (4 * d);
        lz    = blank_lz_i && (d != 0) && (upper == 32'd0);
        if (rst || !en_i || lz) begin
            e_an  = 8'hFF;
            e_seg = 8'hFF;
        end else begin
            e_an  = (c < BLK) ? 8'hFF : ~(8'h01 << d);
            e_seg = {1'b1, glyph_tbl[upper[3:0]]};
        end
        e_fr = !rst && en_i && (pos % FRAME == FRAME - 1);
        if (rst) begin
            pos    = 0;
            shadow = '0;
        end else if (en_i) begin
            if (pos % FRAME == FRAME - 1) shadow = data_i;
            pos++;
        end
        @(posedge clk);
        #1;
        check("an_o", {24'd0, an_o}, {24'd0, e_an});
        check("seg_o", {24'd0, seg_o}, {24'd0, e_seg});
        check("frame_o", {31'd0, frame_o}, {31'd0, e_fr});
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < FRAME && (pos % FRAME) != target; k++) step();
        check("reach_pos", pos % FRAME, target);
    endtask

    initial begin
        // Reset state
        run(3);
        rst = 1'b0;

        // Reset release: zeros until the first frame, then the scan order of 0x12345678
        run(FRAME + 2 * FRAME);

        // Tearing: change mid-frame, new value only after the next frame pulse
        run_to(20);
        data_i = 32'hFFFF_FFFF;
        run(2 * FRAME);

        // Leading-zero blanking
        blank_lz_i = 1'b1;
        data_i     = 32'h0000_00A0;
        run(2 * FRAME + 10);
        data_i = 32'h0;
        run(2 * FRAME);
        data_i = 32'h0012_3000;
        run(FRAME + 30);
        blank_lz_i = 1'b0;
        run(FRAME);

        // Enable drop mid-slot for 20 cycles
        data_i = 32'h89AB_CDEF;
        run(FRAME);
        run_to(27);
        en_i = 1'b0;
        run(20);
        en_i = 1'b1;
        run(2 * FRAME);

        // Reset mid-frame at idx 5, cnt 4
        run_to(5 * DIV + 4);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(FRAME + 10);

        // Random soak
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) data_i = $urandom;
            if ($urandom_range(0, 7) == 0) data_i = $urandom & 32'h0000_0FFF;
            en_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 40) == 0) blank_lz_i = ~blank_lz_i;
            rst = ($urandom_range(0, 400) == 0);
            step();
        end
        rst  = 1'b0;
        en_i = 1'b1;
        run(FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit slot; SHALL be >= 4.
REQ-002 Parameter BLANK_CYC, default 16: anti-ghost blanking cycles at the start of each slot; SHALL be < REFRESH_DIV.
REQ-003 clk  input  1  single clock, the divided core clock of the SoC top.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 data_i  input  32  value to display; connects to the core's LED output register bus.
REQ-006 en_i  input  1  display enable; low blanks all digits and freezes scanning.
REQ-007 blank_lz_i  input  1  leading-zero blanking enable.
REQ-008 seg_o  output  8  segments {dp,g,f,e,d,c,b,a}, active-low.
REQ-009 an_o  output  8  digit selects, active-low; bit i drives digit i, where digit 0 is rightmost.
REQ-010 frame_o  output  1  one-cycle pulse: new shadow value latched.

Function
REQ-011 Prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap while en_i=1; it SHALL hold while en_i=0.
REQ-012 Digit index idx (3 bits) SHALL increment on cnt==REFRESH_DIV-1 with en_i=1; 7 SHALL wrap to 0.
REQ-013 A frame boundary is cnt==REFRESH_DIV-1, idx==7, en_i=1.
REQ-014 At a frame boundary the 32-bit shadow register SHALL load data_i sampled in that cycle.
REQ-015 frame_o SHALL be 1 in the cycle following a frame boundary, and 0 otherwise.
REQ-016 data_i changes between frame boundaries SHALL NOT affect the display (no tearing).
REQ-017 Digit i SHALL show nibble shadow[4i+3:4i], decoded to hex glyphs 0-9 and A-F.
REQ-018 The glyph encoding is fixed as follows (active-low, {g..a}):
- 0 = 0x40, 1 = 0x79, 2 = 0x24, 3 = 0x30, 4 = 0x19, 5 = 0x12, 6 = 0x02, 7 = 0x78
- 8 = 0x00, 9 = 0x10, A = 0x08, b = 0x03, C = 0x46, d = 0x21, E = 0x06, F = 0x0E
- dp SHALL always be 1 (off).
REQ-019 Digit i (i>0) SHALL be blanked when blank_lz_i=1 and nibbles i..7 of shadow are all zero.
- Blanked means an_o=8'hFF and seg_o=8'hFF for that slot.
- Digit 0 SHALL never be lz-blanked.
REQ-020 When cnt < BLANK_CYC, an_o SHALL be 8'hFF (anti-ghost gap).
REQ-021 Otherwise an_o SHALL have exactly bit idx low.
REQ-022 seg_o and an_o SHALL be registered, reflecting cnt/idx/shadow of the previous cycle (1-cycle latency).
REQ-023 With en_i=0, an_o=8'hFF and seg_o=8'hFF from the next cycle on; idx, cnt and shadow SHALL hold.
- When en_i returns to 1, scanning SHALL resume from the held state.
REQ-024 If blank_lz_i changes mid-frame, it SHALL take effect from the next cycle.

Reset
REQ-025 While rst=1 at a clk edge, the following SHALL be set after that edge:
- cnt=0, idx=0, shadow=0
- an_o=8'hFF, seg_o=8'hFF, frame_o=0
REQ-026 Reset mid-slot or mid-frame SHALL abandon the current frame; no frame_o pulse SHALL result.
REQ-027 After reset the display SHALL show shadow=0 until the first frame boundary.

Structure
REQ-028 The glyph table, segment/anode polarity constants and the 32-bit bus width SHALL live in the shared defines include file.
REQ-029 One combinational sub-module, seg7_decode (4-bit nibble -> 7-bit active-low segments), SHALL be instantiated once.
REQ-030 seg7_scan SHALL sit in the SoC top on the divided clock and reset, consuming the core LED output bus.

Verification (REFRESH_DIV=8, BLANK_CYC=2)
REQ-031 Reset release:
- data_i=0x12345678, en_i=1, blank_lz_i=0.
- Before the first frame boundary all digits show glyph 0x40; an_o=8'hFF during the first 2 cycles of each slot.
- frame_o pulses at cycle 64.
REQ-032 Scan order: after the first frame, slots 0..7 show the following, each with an_o low only at bit idx for cycles 2..7 of the slot:
- 8 (0x00), 7 (0x78), 6 (0x02), 5 (0x12)
- 4 (0x19), 3 (0x30), 2 (0x24), 1 (0x79)
REQ-033 Tearing: change data_i to 0xFFFFFFFF mid-frame -> the display keeps 0x12345678 until the next frame_o, then shows F (0x0E) on all digits.
REQ-034 Leading zeros: data_i=0x000000A0, blank_lz_i=1 -> digits 2..7 have an_o=8'hFF; digit 1 shows 0x08; digit 0 shows 0x40.
- With data_i=0, only digit 0 lights.
REQ-035 Enable: drop en_i for 20 cycles mid-slot -> outputs 8'hFF from the next cycle, cnt/idx frozen; they resume at the same cnt/idx after en_i returns.
REQ-036 Reset mid-frame: assert rst at idx=5, cnt=4 -> the next cycle has an_o=8'hFF, idx=0, shadow=0, and no frame_o pulse.
